// File: rtl/layer_sequencer.sv
// Layer sequencer: launches NUM_LAYER layers per start_CNN and ping-pongs the OFM regions between layers.
// Optional watchdog with ERR state is enabled by defining LAYER_TIMEOUT_EN.
module layer_sequencer #(
    parameter int unsigned       NUM_LAYER      = 10,
    parameter int unsigned       ADDR_W         = 22,
    parameter logic [ADDR_W-1:0] OFM_BASE_A     = '0,
    parameter logic [ADDR_W-1:0] OFM_BASE_B     = ADDR_W'(1393600),
    parameter int unsigned       TIMEOUT_CYCLES = 1 << 24
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start_CNN,
    input  logic                         layer_done,
    output logic                         start_layer,
    output logic [$clog2(NUM_LAYER)-1:0] count_layer,
    output logic                         ifm_from_ofm,
    output logic [ADDR_W-1:0]            ifm_base_addr,
    output logic [ADDR_W-1:0]            ofm_base_addr,
    output logic                         busy,
    output logic                         done_CNN,
    output logic                         err
);

    localparam int unsigned CW = $clog2(NUM_LAYER);
    localparam logic [CW-1:0] LAST_LAYER = CW'(NUM_LAYER - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_RUN,
        S_NEXT,
        S_DONE
`ifdef LAYER_TIMEOUT_EN
        , S_ERR
`endif
    } state_t;

    state_t state;

`ifdef LAYER_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_count;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            start_layer   <= 1'b0;
            count_layer   <= '0;
            ifm_from_ofm  <= 1'b0;
            ifm_base_addr <= '0;
            ofm_base_addr <= '0;
            busy          <= 1'b0;
            done_CNN      <= 1'b0;
`ifdef LAYER_TIMEOUT_EN
            err           <= 1'b0;
            wd_count      <= '0;
`endif
        end else begin
            start_layer <= 1'b0;
            done_CNN    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_CNN) begin
                        state         <= S_LAUNCH;
                        start_layer   <= 1'b1;
                        busy          <= 1'b1;
                        count_layer   <= '0;
                        ifm_from_ofm  <= 1'b0;
                        ifm_base_addr <= '0;
                        ofm_base_addr <= OFM_BASE_A;
                    end
                end
                S_LAUNCH: begin
                    state <= S_RUN;
`ifdef LAYER_TIMEOUT_EN
                    wd_count <= '0;
`endif
                end
                S_RUN: begin
                    if (layer_done) begin
                        if (count_layer == LAST_LAYER) begin
                            state    <= S_DONE;
                            done_CNN <= 1'b1;
                        end else begin
                            state <= S_NEXT;
                        end
                    end
`ifdef LAYER_TIMEOUT_EN
                    else if (wd_count == WD_W'(TIMEOUT_CYCLES - 1)) begin
                        state <= S_ERR;
                        err   <= 1'b1;
                    end else begin
                        wd_count <= wd_count + 1'b1;
                    end
`endif
                end
                S_NEXT: begin
                    // Next layer reads what this layer wrote; parity of the new index picks its write region.
                    state         <= S_LAUNCH;
                    start_layer   <= 1'b1;
                    count_layer   <= count_layer + 1'b1;
                    ifm_from_ofm  <= 1'b1;
                    ifm_base_addr <= ofm_base_addr;
                    ofm_base_addr <= count_layer[0] ? OFM_BASE_A : OFM_BASE_B;
                end
                S_DONE: begin
                    state         <= S_IDLE;
                    busy          <= 1'b0;
                    count_layer   <= '0;
                    ifm_from_ofm  <= 1'b0;
                    ifm_base_addr <= '0;
                    ofm_base_addr <= OFM_BASE_A;
                end
`ifdef LAYER_TIMEOUT_EN
                S_ERR: begin
                    state <= S_ERR;
                    err   <= 1'b1;
                    busy  <= 1'b1;
                end
`endif
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_layer_sequencer.sv
// Self-checking bench for layer_sequencer: per-layer expectations are queued when a run is
// requested and popped at each start_layer pulse.
module tb_layer_sequencer;

    localparam int NL = 10;
    localparam int AW = 22;
    localparam int BA = 0;
    localparam int BB = 1393600;
    localparam int TO = 100;

    localparam int M_PLAIN = 0;
    localparam int M_SPUR  = 1;
    localparam int M_RESET = 2;
    localparam int M_HANG  = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start_CNN;
    logic          layer_done;
    logic          start_layer;
    logic [3:0]    count_layer;
    logic          ifm_from_ofm;
    logic [AW-1:0] ifm_base_addr;
    logic [AW-1:0] ofm_base_addr;
    logic          busy;
    logic          done_CNN;
    logic          err;

    layer_sequencer #(
        .NUM_LAYER(NL),
        .ADDR_W(AW),
        .OFM_BASE_A(22'(BA)),
        .OFM_BASE_B(22'(BB)),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start_CNN(start_CNN),
        .layer_done(layer_done),
        .start_layer(start_layer),
        .count_layer(count_layer),
        .ifm_from_ofm(ifm_from_ofm),
        .ifm_base_addr(ifm_base_addr),
        .ofm_base_addr(ofm_base_addr),
        .busy(busy),
        .done_CNN(done_CNN),
        .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cnt;
        bit rd_ofm;
        int ifm;
        int ofm;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: even layers write region A, odd write B, each layer reads its predecessor's output.
    task automatic push_run();
        exp_t e;
        for (int k = 0; k < NL; k++) begin
            e.cnt    = k;
            e.ofm    = (k % 2 == 1) ? BB : BA;
            e.rd_ofm = (k > 0);
            e.ifm    = (k > 0) ? (((k - 1) % 2 == 1) ? BB : BA) : 0;
            exp_q.push_back(e);
        end
    endtask

    task automatic kick(input bit hold, input int runs);
        start_CNN = 1'b1;
        for (int r = 0; r < runs; r++) push_run();
        @(negedge clk);
        if (!hold) start_CNN = 1'b0;
    endtask

    task automatic do_run(input int mode, input int abort_layer);
        exp_t e;
        int   starts;
        int   extra;
        int   bad;
        starts = 0;
        for (int k = 0; k < NL; k++) begin
            n_checks++;
            if (start_layer !== 1'b1) begin
                n_fail++;
                $display("FAIL start_lat layer %0d: got %b expected 1", k, start_layer);
            end else begin
                starts++;
            end
            if (exp_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL sb_underflow layer %0d: got empty queue expected an entry", k);
                e.cnt = k; e.rd_ofm = 1'b0; e.ifm = 0; e.ofm = 0;
            end else begin
                e = exp_q.pop_front();
                n_checks++;
                if (int'(count_layer) !== e.cnt) begin
                    n_fail++;
                    $display("FAIL count_layer: got %0d expected %0d", count_layer, e.cnt);
                end
                n_checks++;
                if (ifm_from_ofm !== e.rd_ofm) begin
                    n_fail++;
                    $display("FAIL ifm_from_ofm layer %0d: got %b expected %b", k, ifm_from_ofm, e.rd_ofm);
                end
                n_checks++;
                if (int'(ifm_base_addr) !== e.ifm) begin
                    n_fail++;
                    $display("FAIL ifm_base layer %0d: got %0d expected %0d", k, ifm_base_addr, e.ifm);
                end
                n_checks++;
                if (int'(ofm_base_addr) !== e.ofm) begin
                    n_fail++;
                    $display("FAIL ofm_base layer %0d: got %0d expected %0d", k, ofm_base_addr, e.ofm);
                end
            end

            if (mode == M_HANG && k == abort_layer) begin
                bad = 0;
                for (int i = 1; i <= 200; i++) begin
                    @(negedge clk);
                    if (done_CNN === 1'b1) bad++;
`ifdef LAYER_TIMEOUT_EN
                    if (err === 1'b1 && extra == 0) extra = i;
`endif
                end
`ifdef LAYER_TIMEOUT_EN
                n_checks++;
                if (extra !== TO + 1) begin
                    n_fail++;
                    $display("FAIL timeout_lat: got err at cycle %0d expected %0d", extra, TO + 1);
                end
                n_checks++;
                if ({err, busy} !== 2'b11) begin
                    n_fail++;
                    $display("FAIL err_hold: got err=%b busy=%b expected 1 1", err, busy);
                end
`else
                n_checks++;
                if ({err, busy, count_layer} !== {2'b01, 4'(k)}) begin
                    n_fail++;
                    $display("FAIL hang_wait: got err=%b busy=%b cnt=%0d expected 0 1 %0d", err, busy, count_layer, k);
                end
`endif
                n_checks++;
                if (bad !== 0) begin
                    n_fail++;
                    $display("FAIL hang_done: got %0d done pulses expected 0", bad);
                end
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                n_checks++;
                if ({err, busy} !== 2'b00) begin
                    n_fail++;
                    $display("FAIL hang_reset: got err=%b busy=%b expected 0 0", err, busy);
                end
                exp_q.delete();
                return;
            end

            if (mode == M_SPUR && k == 4) layer_done = 1'b1;
            extra = 0;
            for (int c = 1; c <= 50; c++) begin
                @(negedge clk);
                layer_done = 1'b0;
                if (start_layer === 1'b1) extra++;
                if (mode == M_SPUR && k == 3 && c == 10) start_CNN = 1'b1;
                if (mode == M_SPUR && k == 3 && c == 11) start_CNN = 1'b0;
                if (c == 25) begin
                    n_checks++;
                    if ({busy, count_layer, ofm_base_addr} !== {1'b1, 4'(k), 22'(e.ofm)}) begin
                        n_fail++;
                        $display("FAIL run_stable layer %0d: got busy=%b cnt=%0d ofm=%0d expected 1 %0d %0d",
                                 k, busy, count_layer, ofm_base_addr, k, e.ofm);
                    end
                end
                if (mode == M_RESET && k == abort_layer && c == 20) begin
                    #2 rst_n = 1'b0;
                    #1;
                    n_checks++;
                    if ({start_layer, busy, done_CNN, err, ifm_from_ofm, count_layer, ifm_base_addr, ofm_base_addr} !== '0) begin
                        n_fail++;
                        $display("FAIL async_reset: got sl=%b busy=%b done=%b err=%b rd=%b cnt=%0d ifm=%0d ofm=%0d expected all 0",
                                 start_layer, busy, done_CNN, err, ifm_from_ofm, count_layer, ifm_base_addr, ofm_base_addr);
                    end
                    @(negedge clk);
                    rst_n = 1'b1;
                    bad = 0;
                    for (int i = 0; i < 60; i++) begin
                        @(negedge clk);
                        if (done_CNN !== 1'b0 || busy !== 1'b0 || start_layer !== 1'b0) bad++;
                    end
                    n_checks++;
                    if (bad !== 0) begin
                        n_fail++;
                        $display("FAIL post_reset_idle: got %0d active cycles expected 0", bad);
                    end
                    exp_q.delete();
                    return;
                end
                if (c == 50) layer_done = 1'b1;
            end
            n_checks++;
            if (extra !== 0) begin
                n_fail++;
                $display("FAIL extra_start layer %0d: got %0d pulses expected 0", k, extra);
            end
            @(negedge clk);
            layer_done = 1'b0;
            n_checks++;
            if (done_CNN !== (k == NL - 1)) begin
                n_fail++;
                $display("FAIL done_pulse layer %0d: got %b expected %b", k, done_CNN, (k == NL - 1));
            end
            @(negedge clk);
            if (k == NL - 1) begin
                n_checks++;
                if ({busy, done_CNN, count_layer} !== 6'b0) begin
                    n_fail++;
                    $display("FAIL run_end: got busy=%b done=%b cnt=%0d expected 0 0 0", busy, done_CNN, count_layer);
                end
            end
        end
        n_checks++;
        if (starts !== NL) begin
            n_fail++;
            $display("FAIL start_count: got %0d expected %0d", starts, NL);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start_CNN = 1'b0; layer_done = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({start_layer, busy, done_CNN, err, ifm_from_ofm} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got sl=%b busy=%b done=%b err=%b rd=%b expected 0", start_layer, busy, done_CNN, err, ifm_from_ofm);
        end
        n_checks++;
        if ({count_layer, ifm_base_addr, ofm_base_addr} !== '0) begin
            n_fail++;
            $display("FAIL reset_regs: got cnt=%0d ifm=%0d ofm=%0d expected 0", count_layer, ifm_base_addr, ofm_base_addr);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, start_layer} !== 2'b00) begin
            n_fail++;
            $display("FAIL release_idle: got busy=%b sl=%b expected 0 0", busy, start_layer);
        end
    endtask

    task automatic test_idle_noise();
        layer_done = 1'b1;
        @(negedge clk);
        layer_done = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, start_layer, done_CNN, count_layer} !== 7'b0) begin
            n_fail++;
            $display("FAIL idle_layer_done: got busy=%b sl=%b done=%b cnt=%0d expected 0", busy, start_layer, done_CNN, count_layer);
        end
    endtask

    task automatic test_full_run();
        kick(1'b0, 1);
        do_run(M_PLAIN, 0);
        n_checks++;
        if (exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL sb_empty: got %0d leftover expected 0", exp_q.size());
        end
    endtask

    task automatic test_spurious();
        kick(1'b0, 1);
        do_run(M_SPUR, 0);
    endtask

    task automatic test_reset_mid_run();
        kick(1'b0, 1);
        do_run(M_RESET, 5);
        kick(1'b0, 1);
        do_run(M_PLAIN, 0);
    endtask

    task automatic test_timeout();
        kick(1'b0, 1);
        do_run(M_HANG, 2);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        kick(1'b1, 2);
        do_run(M_PLAIN, 0);
        @(negedge clk);
        start_CNN = 1'b0;
        do_run(M_PLAIN, 0);
        repeat (5) @(negedge clk);
        n_checks++;
        if ({busy, exp_q.size() == 0} !== 2'b01) begin
            n_fail++;
            $display("FAIL b2b_end: got busy=%b leftover=%0d expected 0 0", busy, exp_q.size());
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        test_reset();
        test_idle_noise();
        test_full_run();
        test_spurious();
        test_reset_mid_run();
        test_timeout();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/layer_sequencer.md
LAYER_SEQUENCER -- requirements
Module: layer_sequencer

Interface
REQ-001 SHALL have parameter NUM_LAYER, default 10: number of network layers run per start_CNN.
REQ-002 SHALL have parameter ADDR_W, default 22: OFM RAM address width.
REQ-003 SHALL have parameter OFM_BASE_A, default 0: OFM region written by even layers.
REQ-004 SHALL have parameter OFM_BASE_B, default 1393600: OFM region written by odd layers.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 2^24: watchdog limit (used only under LAYER_TIMEOUT_EN).
REQ-006 clk  input  1  single clock; all state changes on its rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 start_CNN  input  1  request to run all layers; sampled only in IDLE.
REQ-009 layer_done  input  1  single-cycle pulse from the layer datapath when the current layer completes.
REQ-010 start_layer  output  1  single-cycle pulse that launches the current layer.
REQ-011 count_layer  output  $clog2(NUM_LAYER)  index of the current layer, 0-based.
REQ-012 ifm_from_ofm  output  1  0 = layer reads IFM RAM; 1 = layer reads OFM RAM.
REQ-013 ifm_base_addr  output  ADDR_W  read base address of the current layer in OFM RAM.
REQ-014 ofm_base_addr  output  ADDR_W  write base address of the current layer.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done_CNN  output  1  single-cycle pulse after the last layer completes.
REQ-017 err  output  1  watchdog error flag; tied 0 without LAYER_TIMEOUT_EN.

Function
REQ-018 The FSM SHALL have states IDLE, LAUNCH, RUN, NEXT, DONE, plus ERR under LAYER_TIMEOUT_EN.
REQ-019 On start_CNN=1, IDLE SHALL go to LAUNCH with count_layer=0; start_layer SHALL pulse in the cycle after start_CNN is sampled.
REQ-020 LAUNCH SHALL assert start_layer for exactly one cycle and then go to RUN.
REQ-021 In RUN, layer_done=1 SHALL go to DONE if count_layer==NUM_LAYER-1, otherwise to NEXT.
REQ-022 NEXT SHALL increment count_layer by 1 and go to LAUNCH, so the next start_layer is 2 cycles after layer_done.
REQ-023 DONE SHALL assert done_CNN for one cycle (the cycle after the final layer_done), clear count_layer to 0 and return to IDLE.
REQ-024 ofm_base_addr SHALL be OFM_BASE_A when count_layer is even and OFM_BASE_B when it is odd.
REQ-025 For count_layer==0, ifm_from_ofm SHALL be 0 and ifm_base_addr SHALL be 0.
REQ-026 For count_layer>0, ifm_from_ofm SHALL be 1 and ifm_base_addr SHALL equal the previous layer's ofm_base_addr.
REQ-027 count_layer, ifm_from_ofm, ifm_base_addr and ofm_base_addr SHALL be registered.
REQ-028 Those outputs SHALL be valid in the start_layer cycle and stable until the next NEXT or DONE.
REQ-029 start_CNN outside IDLE SHALL be ignored.
REQ-030 layer_done outside RUN, including in the LAUNCH cycle, SHALL be ignored.
REQ-031 start_CNN asserted in the DONE cycle SHALL be ignored; a new start needs start_CNN sampled in IDLE.
REQ-032 A start_CNN held high continuously SHALL start one run per visit to IDLE.

Reset
REQ-033 While rst_n=0, the block SHALL be in IDLE with count_layer=0 and every output 0.
REQ-034 Asserting rst_n mid-run SHALL abort immediately with no done_CNN.
REQ-035 After release, the block SHALL wait for a fresh start_CNN.

Configuration
REQ-036 With macro LAYER_TIMEOUT_EN defined, a watchdog counter SHALL clear in LAUNCH and increment each RUN cycle.
REQ-037 Under LAYER_TIMEOUT_EN, if the counter reaches TIMEOUT_CYCLES without layer_done, the FSM SHALL go to ERR.
REQ-038 ERR SHALL hold err=1 and busy=1 until reset; done_CNN SHALL never assert from ERR.
REQ-039 Without LAYER_TIMEOUT_EN, the watchdog counter and ERR SHALL not exist, err SHALL be constant 0, and RUN SHALL wait for layer_done indefinitely.

Verification
REQ-040 Full run: reset, start_CNN pulse, layer_done 50 cycles after each start_layer -> exactly 10 start_layer pulses; count_layer 0..9; done_CNN one cycle after the 10th layer_done; busy then falls.
REQ-041 Address ping-pong: same run -> ofm_base_addr 0,1393600,0,... ending 1393600 at layer 9; ifm_from_ofm=0 only for layer 0; ifm_base_addr(k) = ofm_base_addr(k-1).
REQ-042 Spurious inputs: start_CNN pulsed in RUN at layer 3, layer_done pulsed while IDLE and in the LAUNCH cycle -> no state change, no extra start_layer.
REQ-043 Reset mid-run: rst_n low during RUN of layer 5 -> all outputs 0 asynchronously, no done_CNN; a following start_CNN restarts at layer 0.
REQ-044 Timeout (LAYER_TIMEOUT_EN, TIMEOUT_CYCLES=100): layer 2 never sends layer_done -> err=1 exactly 100 RUN cycles after start_layer; no done_CNN; reset clears err.
REQ-045 Back-to-back runs: start_CNN held high -> second run's first start_layer follows the DONE->IDLE return by 2 cycles, with count_layer=0.
